// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width, transmit FSM encodings and clog2 helper for the UART TX FIFO slice.
package uart_pkg;
   localparam int UART_BYTE_W = 8;
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_REQ  = 2'b01;
   localparam logic [1:0] S_WAIT = 2'b10;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: push side and transmitter req/busy handshake of uart_tx_fifo.
// overflow/ovf_clr exist only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if #(
   parameter int DEPTH = 16,
   parameter int AW    = uart_pkg::clog2(DEPTH)
);
   import uart_pkg::*;
   logic                   wr_en;
   logic [UART_BYTE_W-1:0] wr_data;
   logic                   full;
   logic                   empty;
   logic [AW:0]            level;
   logic                   tx_busy;
   logic                   tx_req;
   logic [UART_BYTE_W-1:0] tx_byte;
`ifdef UART_TX_FIFO_OVF_EN
   logic                   overflow;
   logic                   ovf_clr;
`endif
   modport slave (
      input  wr_en, wr_data, tx_busy,
      output full, empty, level, tx_req, tx_byte
`ifdef UART_TX_FIFO_OVF_EN
      , input ovf_clr, output overflow
`endif
   );
   modport master (
      output wr_en, wr_data, tx_busy,
      input  full, empty, level, tx_req, tx_byte
`ifdef UART_TX_FIFO_OVF_EN
      , output ovf_clr, input overflow
`endif
   );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: circular byte store with level counter and a read register loaded on demand.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [UART_BYTE_W-1:0] wr_data,
   input  logic                   pop,
   input  logic                   load,
   output logic                   full,
   output logic                   empty,
   output logic [AW:0]            level,
   output logic [UART_BYTE_W-1:0] rd_data
);
   logic [UART_BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]            level_q, level_d;
   logic [UART_BYTE_W-1:0] rd_data_q, rd_data_d;
   logic                   push;

   assign full    = level_q == (AW+1)'(DEPTH);
   assign empty   = level_q == '0;
   assign level   = level_q;
   assign rd_data = rd_data_q;

   always_comb begin
      push      = wr_en && (!full || pop);
      wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
      rd_data_d = load ? mem_q[rd_ptr_q] : rd_data_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         rd_data_q <= rd_data_d;
      end

   // Storage needs no reset; the level counter alone says what is valid.
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter one frame at a time over req/busy.
// Define UART_TX_FIFO_OVF_EN for the sticky overflow flag and its ovf_clr input.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = clog2(DEPTH)
) (
   input logic           clk,
   input logic           rst_n,
   uart_tx_fifo_if.slave bus
);
   logic [1:0] state_q, state_d;
   logic       tx_req_q, tx_req_d;
   logic       load, pop;

   // The byte stays counted in level until the transmitter has taken it.
   always_comb begin
      load     = state_q == S_IDLE && !bus.empty && !bus.tx_busy;
      pop      = state_q == S_REQ && bus.tx_busy;
      state_d  = load ? S_REQ
               : pop ? S_WAIT
               : (state_q == S_WAIT && !bus.tx_busy) || state_q == 2'b11 ? S_IDLE
               : state_q;
      tx_req_d = state_d == S_REQ;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= S_IDLE;
         tx_req_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_req_q <= tx_req_d;
      end

   assign bus.tx_req = tx_req_q;

   uart_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.wr_en),
      .wr_data (bus.wr_data),
      .pop     (pop),
      .load    (load),
      .full    (bus.full),
      .empty   (bus.empty),
      .level   (bus.level),
      .rd_data (bus.tx_byte)
   );

`ifdef UART_TX_FIFO_OVF_EN
   logic overflow_q, overflow_d;

   always_comb
      overflow_d = bus.wr_en && bus.full && !pop ? 1'b1 : bus.ovf_clr ? 1'b0 : overflow_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;

   assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo against a negedge-driven model transmitter.
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DEPTH(16)) b ();
   uart_tx_fifo dut (.clk(clk), .rst_n(rst_n), .bus(b));

   int checks = 0;
   int errors = 0;
   bit auto_en = 1'b1;
   bit stall = 1'b0;
   int len_max = 3;
   int cnt = 0;
   logic prev_req = 1'b0;
   logic [7:0] rxq[$];
   logic [7:0] expq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model transmitter: accepts a request on a falling edge, stays busy a random number of cycles.
   always @(negedge clk) begin
      if (b.tx_req && !prev_req) chk("req_while_busy", {31'd0, b.tx_busy}, 32'd0);
      prev_req = b.tx_req;
      if (!rst_n) begin
         b.tx_busy = 1'b0;
         cnt = 0;
      end else if (b.tx_busy) begin
         if (!stall) begin
            if (cnt == 0) b.tx_busy = 1'b0;
            else cnt--;
         end
      end else if (b.tx_req && auto_en) begin
         b.tx_busy = 1'b1;
         cnt = $urandom_range(0, len_max);
         rxq.push_back(b.tx_byte);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      b.wr_en = 1'b1;
      b.wr_data = d;
      tick();
      b.wr_en = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (!(b.empty && !b.tx_busy && !b.tx_req) && k < 3000) begin
         tick();
         k++;
      end
      chk("drain_done", {31'd0, k < 3000}, 32'd1);
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_count"}, rxq.size(), expq.size());
      for (int i = 0; i < rxq.size() && i < expq.size(); i++) chk(tag, {24'd0, rxq[i]}, {24'd0, expq[i]});
      rxq.delete();
      expq.delete();
   endtask

   initial begin
      int n;
      int maxl;
      b.wr_en = 1'b0;
      b.wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
      b.ovf_clr = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_tx_req", {31'd0, b.tx_req}, 32'd0);
      chk("rst_tx_byte", {24'd0, b.tx_byte}, 32'h00);
      chk("rst_full", {31'd0, b.full}, 32'd0);
      chk("rst_empty", {31'd0, b.empty}, 32'd1);
      chk("rst_level", {27'd0, b.level}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
      chk("rst_overflow", {31'd0, b.overflow}, 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // T1 single byte
      push(8'hA5);
      expq.push_back(8'hA5);
      chk("t1_level_after_push", {27'd0, b.level}, 32'd1);
      chk("t1_no_req_yet", {31'd0, b.tx_req}, 32'd0);
      tick();
      chk("t1_req", {31'd0, b.tx_req}, 32'd1);
      chk("t1_byte", {24'd0, b.tx_byte}, 32'hA5);
      tick();
      chk("t1_req_dropped", {31'd0, b.tx_req}, 32'd0);
      chk("t1_level_popped", {27'd0, b.level}, 32'd0);
      chk("t1_empty", {31'd0, b.empty}, 32'd1);
      chk("t1_byte_held", {24'd0, b.tx_byte}, 32'hA5);
      drain();
      check_stream("t1_stream");

      // T2 burst of 16 with the transmitter initially not accepting
      auto_en = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         push(8'(i));
         expq.push_back(8'(i));
      end
      chk("t2_level", {27'd0, b.level}, 32'd16);
      chk("t2_full", {31'd0, b.full}, 32'd1);
      chk("t2_req_held", {31'd0, b.tx_req}, 32'd1);
      chk("t2_head", {24'd0, b.tx_byte}, 32'h01);
      auto_en = 1'b1;
      drain();
      chk("t2_empty", {31'd0, b.empty}, 32'd1);
      check_stream("t2_stream");

      // T3 overflow with the transmitter stuck busy
      stall = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         push(8'h20 + 8'(i));
         expq.push_back(8'h20 + 8'(i));
      end
      chk("t3_level_full", {27'd0, b.level}, 32'd16);
      chk("t3_busy_held", {31'd0, b.tx_busy}, 32'd1);
      push(8'hFF);
      chk("t3_level_after_drop", {27'd0, b.level}, 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
      chk("t3_overflow_set", {31'd0, b.overflow}, 32'd1);
      b.ovf_clr = 1'b1;
      tick();
      b.ovf_clr = 1'b0;
      chk("t3_overflow_clr", {31'd0, b.overflow}, 32'd0);
      b.ovf_clr = 1'b1;
      push(8'hFF);
      b.ovf_clr = 1'b0;
      chk("t3_set_beats_clr", {31'd0, b.overflow}, 32'd1);
      b.ovf_clr = 1'b1;
      tick();
      b.ovf_clr = 1'b0;
      chk("t3_overflow_clr2", {31'd0, b.overflow}, 32'd0);
`endif
      stall = 1'b0;
      drain();
      check_stream("t3_stream");

      // T4 push while full on the exact pop cycle
      auto_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push(8'h40 + 8'(i));
         expq.push_back(8'h40 + 8'(i));
      end
      chk("t4_full_before", {31'd0, b.full}, 32'd1);
      auto_en = 1'b1;
      push(8'h55);
      expq.push_back(8'h55);
      chk("t4_level", {27'd0, b.level}, 32'd16);
      chk("t4_full", {31'd0, b.full}, 32'd1);
      chk("t4_req_low", {31'd0, b.tx_req}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
      chk("t4_no_overflow", {31'd0, b.overflow}, 32'd0);
`endif
      drain();
      check_stream("t4_stream");

      // T5 reset mid-frame
      auto_en = 1'b0;
      for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
      tick();
      chk("t5_req_before", {31'd0, b.tx_req}, 32'd1);
      chk("t5_level_before", {27'd0, b.level}, 32'd5);
      rst_n = 1'b0;
      #1;
      chk("t5_req_reset", {31'd0, b.tx_req}, 32'd0);
      chk("t5_empty_reset", {31'd0, b.empty}, 32'd1);
      chk("t5_level_reset", {27'd0, b.level}, 32'd0);
      chk("t5_byte_reset", {24'd0, b.tx_byte}, 32'h00);
      tick();
      tick();
      rst_n = 1'b1;
      auto_en = 1'b1;
      repeat (20) tick();
      chk("t5_no_stale_req", {31'd0, b.tx_req}, 32'd0);
      check_stream("t5_stream");

      // T6 random-rate pushes across pointer wrap
      n = 0;
      maxl = 0;
      for (int cyc = 0; cyc < 2000 && n < 40; cyc++) begin
         if (!b.full && $urandom_range(0, 2) != 0) begin
            b.wr_en = 1'b1;
            b.wr_data = 8'h80 + 8'(n);
            expq.push_back(8'h80 + 8'(n));
            n++;
         end else b.wr_en = 1'b0;
         tick();
         if (int'(b.level) > maxl) maxl = int'(b.level);
      end
      b.wr_en = 1'b0;
      chk("t6_pushed", n, 40);
      chk("t6_level_bound", {31'd0, maxl <= 16}, 32'd1);
      drain();
      check_stream("t6_stream");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
